// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Multi-read-port register file. Each register has a scoreboard busy bit.
// Register 0 always reads as zero and is never busy. Indices at or above
// NUM_REGS are treated as non-existent: they read 0 and are never busy.
// Writes and busy-set requests that use such an index are dropped.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset; clears storage and busy bits
//   wr_en         write strobe
//   wr_reg        write index
//   wr_data       write data
//   rd_reg        packed read indices, port p at [p*AW +: AW]
//   rd_data       packed read data, port p at [p*XLEN +: XLEN] (combinational)
//   rd_busy       per-port busy flag of the addressed register (registered state)
//   busy_set_en   mark busy_set_reg as awaiting writeback
//   busy_set_reg  index to mark busy
//   busy_cnt      number of registers currently busy
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter  int XLEN         = 32,
    parameter  int NUM_REGS     = 32,
    parameter  int NUM_RD_PORTS = 2,
    parameter  int BYPASS       = 1,
    localparam int AW           = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_reg,
    input  logic [XLEN-1:0]              wr_data,
    input  logic [NUM_RD_PORTS*AW-1:0]   rd_reg,
    output logic [NUM_RD_PORTS*XLEN-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]      rd_busy,
    input  logic                         busy_set_en,
    input  logic [AW-1:0]                busy_set_reg,
    output logic [AW:0]                  busy_cnt
);

    localparam logic [AW:0] LP_NREGS = (AW+1)'(NUM_REGS);

    // Register 0 has no storage at all; it falls out of the read mux as zero.
    logic [XLEN-1:0]     r_mem [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] r_busy;
    logic [AW:0]         r_busy_cnt;

    logic [NUM_REGS-1:1] w_busy_nxt;
    logic [AW:0]         w_busy_cnt_nxt;
    logic                w_wr_ok;
    logic                w_set_ok;
    logic                w_bypass_ok;
    logic [AW-1:0]       w_rd_idx;

    function automatic logic f_idx_valid(input logic [AW-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < LP_NREGS);
    endfunction

    assign w_wr_ok     = wr_en && f_idx_valid(wr_reg);
    assign w_set_ok    = busy_set_en && f_idx_valid(busy_set_reg);
    // Forwarding is gated by rst_n so reads stay zero while reset is held,
    // even though wr_en may still be asserted by upstream logic.
    assign w_bypass_ok = (BYPASS != 0) && rst_n && w_wr_ok;

    // Next busy state: a write clears, a busy set applied afterwards wins
    // when both target the same register (the new producer owns it).
    always_comb begin
        w_busy_nxt     = r_busy;
        w_busy_cnt_nxt = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (w_wr_ok && (wr_reg == AW'(r))) begin
                w_busy_nxt[r] = 1'b0;
            end
            if (w_set_ok && (busy_set_reg == AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
            w_busy_cnt_nxt = w_busy_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[r]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                r_mem[r] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_wr_ok && (wr_reg == AW'(r))) begin
                    r_mem[r] <= wr_data;
                end
            end
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    // Read mux: compare against each existing register rather than indexing,
    // so index 0 and out-of-range indices naturally produce zero.
    always_comb begin
        rd_data  = '0;
        rd_busy  = '0;
        w_rd_idx = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            w_rd_idx = rd_reg[p*AW +: AW];
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_rd_idx == AW'(r)) begin
                    rd_data[p*XLEN +: XLEN] = r_mem[r];
                    rd_busy[p]              = r_busy[r];
                end
            end
            if (w_bypass_ok && (w_rd_idx == wr_reg)) begin
                rd_data[p*XLEN +: XLEN] = wr_data;
            end
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        bs_en;
    logic [4:0]  bs_reg;
    logic [9:0]  rd_a;
    logic [14:0] rd_b;
    logic [63:0] rdd_a;
    logic [95:0] rdd_b;
    logic [1:0]  rdb_a;
    logic [2:0]  rdb_b;
    logic [5:0]  cnt_a;
    logic [5:0]  cnt_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance 0: 32 registers, 2 ports, forwarding on.
    regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_a), .rd_data(rdd_a), .rd_busy(rdb_a),
        .busy_set_en(bs_en), .busy_set_reg(bs_reg), .busy_cnt(cnt_a));

    // Instance 1: 20 registers, 3 ports, forwarding off.
    regfile_mp #(.XLEN(32), .NUM_REGS(20), .NUM_RD_PORTS(3), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_reg(rd_b), .rd_data(rdd_b), .rd_busy(rdb_b),
        .busy_set_en(bs_en), .busy_set_reg(bs_reg), .busy_cnt(cnt_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [31:0] m_mem [2][32];
    bit          m_bsy [2][32];

    function automatic int nregs(int i);
        return (i == 0) ? 32 : 20;
    endfunction

    function automatic bit has_bypass(int i);
        return (i == 0);
    endfunction

    function automatic bit idx_ok(int i, int idx);
        return (idx != 0) && (idx < nregs(i));
    endfunction

    function automatic logic [31:0] exp_rd(int i, int idx);
        if (!rst_n || !idx_ok(i, idx)) return 32'h0;
        if (has_bypass(i) && wr_en && (int'(wr_reg) == idx)) return wr_data;
        return m_mem[i][idx];
    endfunction

    function automatic logic [31:0] exp_busy(int i, int idx);
        if (!idx_ok(i, idx)) return 32'h0;
        return {31'b0, m_bsy[i][idx]};
    endfunction

    function automatic logic [31:0] exp_cnt(int i);
        int c = 0;
        for (int r = 0; r < 32; r++) c += int'(m_bsy[i][r]);
        return 32'(c);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) begin
                m_mem[i][r] = 32'h0;
                m_bsy[i][r] = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (wr_en && idx_ok(i, int'(wr_reg))) begin
                    m_mem[i][wr_reg] = wr_data;
                    m_bsy[i][wr_reg] = 1'b0;
                end
                if (bs_en && idx_ok(i, int'(bs_reg))) m_bsy[i][bs_reg] = 1'b1;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(int i);
        int np = (i == 0) ? 2 : 3;
        for (int p = 0; p < np; p++) begin
            int          idx = (i == 0) ? int'(rd_a[p*5 +: 5]) : int'(rd_b[p*5 +: 5]);
            logic [31:0] ad  = (i == 0) ? rdd_a[p*32 +: 32] : rdd_b[p*32 +: 32];
            logic        ab  = (i == 0) ? rdb_a[p] : rdb_b[p];
            chk($sformatf("inst%0d rd_data p%0d idx%0d", i, p, idx), ad, exp_rd(i, idx));
            chk($sformatf("inst%0d rd_busy p%0d idx%0d", i, p, idx), {31'b0, ab}, exp_busy(i, idx));
        end
        chk($sformatf("inst%0d busy_cnt", i), {26'b0, (i == 0) ? cnt_a : cnt_b}, exp_cnt(i));
    endtask

    task automatic cycle_checked();
        @(negedge clk);
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_reg = 0; wr_data = 0; bs_en = 0; bs_reg = 0;
    endtask

    // ---------------- directed vector table (instance 0) ----------------
    typedef struct {
        bit          we;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          be;
        logic [4:0]  br;
        logic [4:0]  r0, r1;
        logic [31:0] e0, e1;
        bit          b0, b1;
        int          c;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    initial begin
        tbl[0]  = '{0, 0, 32'h0,        0, 0,  0, 5,  32'h0,        32'h0,        0, 0, 0};
        tbl[1]  = '{1, 5, 32'hDEADBEEF, 0, 0,  3, 0,  32'h0,        32'h0,        0, 0, 0};
        tbl[2]  = '{0, 0, 32'h0,        0, 0,  5, 0,  32'hDEADBEEF, 32'h0,        0, 0, 0};
        tbl[3]  = '{1, 0, 32'hFFFFFFFF, 0, 0,  0, 5,  32'h0,        32'hDEADBEEF, 0, 0, 0};
        tbl[4]  = '{0, 0, 32'h0,        0, 0,  0, 0,  32'h0,        32'h0,        0, 0, 0};
        tbl[5]  = '{1, 7, 32'h12345678, 0, 0,  5, 7,  32'hDEADBEEF, 32'h12345678, 0, 0, 0};
        tbl[6]  = '{0, 0, 32'h0,        1, 9,  9, 7,  32'h0,        32'h12345678, 0, 0, 0};
        tbl[7]  = '{0, 0, 32'h0,        0, 0,  9, 9,  32'h0,        32'h0,        1, 1, 1};
        tbl[8]  = '{1, 9, 32'hAAAA5555, 1, 9,  9, 1,  32'hAAAA5555, 32'h0,        1, 0, 1};
        tbl[9]  = '{0, 0, 32'h0,        0, 0,  9, 0,  32'hAAAA5555, 32'h0,        1, 0, 1};
        tbl[10] = '{1, 9, 32'h0BADF00D, 0, 0,  9, 9,  32'h0BADF00D, 32'h0BADF00D, 1, 1, 1};
        tbl[11] = '{0, 0, 32'h0,        0, 0,  9, 0,  32'h0BADF00D, 32'h0,        0, 0, 0};
        tbl[12] = '{1, 4, 32'h11112222, 1, 3,  3, 4,  32'h0,        32'h11112222, 0, 0, 0};
        tbl[13] = '{0, 0, 32'h0,        0, 0,  3, 4,  32'h0,        32'h11112222, 1, 0, 1};
        tbl[14] = '{0, 0, 32'h0,        1, 0,  0, 3,  32'h0,        32'h0,        0, 1, 1};
        tbl[15] = '{0, 0, 32'h0,        0, 0,  0, 3,  32'h0,        32'h0,        0, 1, 1};
        tbl[16] = '{1, 3, 32'h0,        1, 31, 3, 31, 32'h0,        32'h0,        1, 0, 1};
        tbl[17] = '{0, 0, 32'h0,        0, 0,  3, 31, 32'h0,        32'h0,        0, 1, 1};
        tbl[18] = '{1, 4, 32'h5,        0, 0,  4, 31, 32'h5,        32'h0,        0, 1, 1};
        tbl[19] = '{0, 0, 32'h0,        0, 0,  4, 31, 32'h5,        32'h0,        0, 1, 1};
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        rd_a = '0;
        rd_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sweep every index on every port right after reset.
        for (int idx = 0; idx < 32; idx++) begin
            rd_a = {2{5'(idx)}};
            rd_b = {3{5'(idx)}};
            #1;
            check_inst(0);
            check_inst(1);
        end
        @(posedge clk);
        #1;

        // Directed vectors: instance 0 against constants, instance 1 against model.
        for (int k = 0; k < NV; k++) begin
            wr_en = tbl[k].we; wr_reg = tbl[k].wr; wr_data = tbl[k].wd;
            bs_en = tbl[k].be; bs_reg = tbl[k].br;
            rd_a  = {tbl[k].r1, tbl[k].r0};
            rd_b  = {5'd25, tbl[k].r1, tbl[k].r0};
            @(negedge clk);
            chk($sformatf("vec%0d rd_data0", k), rdd_a[31:0], tbl[k].e0);
            chk($sformatf("vec%0d rd_data1", k), rdd_a[63:32], tbl[k].e1);
            chk($sformatf("vec%0d rd_busy0", k), {31'b0, rdb_a[0]}, {31'b0, tbl[k].b0});
            chk($sformatf("vec%0d rd_busy1", k), {31'b0, rdb_a[1]}, {31'b0, tbl[k].b1});
            chk($sformatf("vec%0d busy_cnt", k), {26'b0, cnt_a}, 32'(tbl[k].c));
            if (k == 5) chk("nobypass x7 port1", rdd_b[63:32], 32'h0);
            check_inst(1);
            @(posedge clk);
            model_edge();
            #1;
        end

        // Out-of-range index 25 on the 20-register instance.
        wr_en = 1; wr_reg = 5'd25; wr_data = 32'hCAFE0001;
        bs_en = 1; bs_reg = 5'd25;
        rd_a = {5'd25, 5'd25};
        rd_b = {5'd25, 5'd25, 5'd25};
        @(negedge clk);
        chk("oor b read25 during write", rdd_b[31:0], 32'h0);
        chk("inst0 bypass x25", rdd_a[31:0], 32'hCAFE0001);
        @(posedge clk);
        model_edge();
        #1;
        idle_inputs();
        @(negedge clk);
        chk("oor b read25 after write", rdd_b[95:64], 32'h0);
        chk("oor b busy25", {29'b0, rdb_b}, 32'h0);
        chk("oor b busy_cnt unchanged", {26'b0, cnt_b}, 32'd0);
        chk("inst0 x25 stored", rdd_a[63:32], 32'hCAFE0001);
        chk("inst0 busy_cnt", {26'b0, cnt_a}, 32'd2);
        check_inst(0);
        check_inst(1);
        @(posedge clk);
        model_edge();
        #1;

        // Randomized traffic with an asynchronous reset pulse in mid-write.
        for (int cyc = 0; cyc < 1000; cyc++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_reg  = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            bs_en   = ($urandom_range(0, 3) == 0);
            bs_reg  = ($urandom_range(0, 3) == 0) ? wr_reg : 5'($urandom_range(0, 31));
            rd_a    = {5'($urandom_range(0, 31)), ($urandom_range(0, 2) == 0) ? wr_reg : 5'($urandom_range(0, 31))};
            rd_b    = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 2) == 0) ? wr_reg : 5'($urandom_range(0, 31))};
            if (cyc == 500) begin
                wr_en  = 1'b1;
                wr_reg = 5'd6;
                rd_a   = {5'd6, 5'd25};
                @(negedge clk);
                check_inst(0);
                check_inst(1);
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check_inst(0);
                check_inst(1);
                for (int idx = 0; idx < 32; idx++) begin
                    rd_a = {2{5'(idx)}};
                    rd_b = {3{5'(idx)}};
                    #1;
                    check_inst(0);
                    check_inst(1);
                end
                @(negedge clk);
                #2 rst_n = 1'b1;
                @(posedge clk);
                model_edge();
                #1;
            end else begin
                cycle_checked();
            end
        end

        idle_inputs();
        cycle_checked();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
